// File: rtl/rf_wb_pkg.sv
// Shared types and default sizing for the register-file writeback arbiter.
package rf_wb_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 32;
    localparam int unsigned DEF_ADDRESS_WIDTH = 5;
    localparam int unsigned DEF_NUM_REGS      = 32;
    localparam int unsigned DEF_FIFO_DEPTH    = 2;
    localparam int unsigned DEF_STARVE_LIMIT  = 3;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LD
    } wb_src_e;

    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0] dest;
        logic [DEF_DATA_WIDTH-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO of writeback requests; head is read combinationally.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t push_data,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_req_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok;
    logic            pop_ok;

    // A pop frees its slot in the same cycle, so push on full is legal alongside it.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Arbitrates the single register-file write port between ALU results and returned loads,
// with a pending-load scoreboard for decode hazard stalls.
module rf_writeback_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
    parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int unsigned STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alu_valid,
    input  logic [ADDRESS_WIDTH-1:0]         alu_dest,
    input  logic [DATA_WIDTH-1:0]            alu_data,
    output logic                             alu_ready,
    input  logic                             ld_issue,
    input  logic [ADDRESS_WIDTH-1:0]         ld_issue_dest,
    output logic                             ld_issue_ready,
    input  logic                             ld_valid,
    input  logic [ADDRESS_WIDTH-1:0]         ld_dest,
    input  logic [DATA_WIDTH-1:0]            ld_data,
    output logic                             ld_ready,
    input  logic [ADDRESS_WIDTH-1:0]         rd_addr1,
    input  logic [ADDRESS_WIDTH-1:0]         rd_addr2,
    output logic                             hazard_stall,
    output logic                             rg_wrt_en,
    output logic [ADDRESS_WIDTH-1:0]         rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]            rg_wrt_data,
    output logic [$clog2(NUM_REGS+1)-1:0]    pend_count
);

    localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned PCW = $clog2(NUM_REGS + 1);

    wb_src_e                 grant;
    wb_req_t                 ld_req;
    wb_req_t                 head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    alu_elig;
    logic                    ld_push;
    logic [NUM_REGS-1:0]     pending_q, pending_d;
    logic [SW-1:0]           starve_q, starve_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDRESS_WIDTH-1:0] wr_dest_q, wr_dest_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [PCW-1:0]          pend_count_q, pend_count_d;

    assign ld_req.dest = ld_dest;
    assign ld_req.data = ld_data;
    assign ld_push     = ld_valid & ld_ready;

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ld_push),
        .pop       (grant == WB_LD),
        .push_data (ld_req),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Grant: a full or starved FIFO beats the ALU; an ALU write to a pending reg must wait.
    always_comb begin
        alu_elig = alu_valid & ~pending_q[alu_dest];
        grant    = WB_NONE;
        if (!rst) begin
            if (!fifo_empty && (fifo_full || starve_q == SW'(STARVE_LIMIT) || !alu_elig)) begin
                grant = WB_LD;
            end else if (alu_elig) begin
                grant = WB_ALU;
            end
        end
    end

    assign alu_ready      = (grant == WB_ALU);
    assign ld_ready       = ~rst & (~fifo_full | (grant == WB_LD));
    assign ld_issue_ready = ~rst & ~pending_q[ld_issue_dest];
    assign hazard_stall   = ((rd_addr1 != '0) & pending_q[rd_addr1]) |
                            ((rd_addr2 != '0) & pending_q[rd_addr2]);

    always_comb begin
        starve_d     = '0;
        pending_d    = pending_q;
        wr_en_d      = 1'b0;
        wr_dest_d    = wr_dest_q;
        wr_data_d    = wr_data_q;
        pend_count_d = '0;

        if (!fifo_empty && grant != WB_LD) begin
            starve_d = starve_q + SW'(1);
        end

        case (grant)
            WB_LD: begin
                pending_d[head.dest] = 1'b0;
                wr_en_d   = (head.dest != '0);
                wr_dest_d = head.dest;
                wr_data_d = head.data;
            end
            WB_ALU: begin
                wr_en_d   = (alu_dest != '0);
                wr_dest_d = alu_dest;
                wr_data_d = alu_data;
            end
            default: ;
        endcase

        // Set after clear so a same-cycle reservation survives the retiring load.
        if (ld_issue && ld_issue_ready && ld_issue_dest != '0) begin
            pending_d[ld_issue_dest] = 1'b1;
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            pend_count_d = pend_count_d + PCW'(pending_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            starve_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_dest_q    <= '0;
            wr_data_q    <= '0;
            pend_count_q <= '0;
        end else begin
            pending_q    <= pending_d;
            starve_q     <= starve_d;
            wr_en_q      <= wr_en_d;
            wr_dest_q    <= wr_dest_d;
            wr_data_q    <= wr_data_d;
            pend_count_q <= pend_count_d;
        end
    end

    assign rg_wrt_en   = wr_en_q;
    assign rg_wrt_dest = wr_dest_q;
    assign rg_wrt_data = wr_data_q;
    assign pend_count  = pend_count_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed and randomized bench for rf_writeback_arbiter against a queue-based reference model.
module tb_rf_writeback_arbiter;

    localparam int DEPTH = 2;
    localparam int LIM   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_dest;
    logic        ld_issue_ready;
    logic        ld_valid;
    logic [4:0]  ld_dest;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        hazard_stall;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_dest;
    logic [31:0] rg_wrt_data;
    logic [5:0]  pend_count;

    rf_writeback_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_dest       (alu_dest),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .ld_issue       (ld_issue),
        .ld_issue_dest  (ld_issue_dest),
        .ld_issue_ready (ld_issue_ready),
        .ld_valid       (ld_valid),
        .ld_dest        (ld_dest),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .rd_addr1       (rd_addr1),
        .rd_addr2       (rd_addr2),
        .hazard_stall   (hazard_stall),
        .rg_wrt_en      (rg_wrt_en),
        .rg_wrt_dest    (rg_wrt_dest),
        .rg_wrt_data    (rg_wrt_data),
        .pend_count     (pend_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    ent_t        mq[$];
    bit          mpend[32];
    int          mstarve;
    bit          m_en;
    bit          m_unsure;
    logic [4:0]  m_dest;
    logic [31:0] m_data;
    int          m_pc;
    logic        s_alu_ready, s_ld_ready, s_issue_ready, s_stall;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs, advance the model at posedge, check registers.
    task automatic cycle();
        bit   elig, take_ld, e_alu, e_ld, e_iss, e_stall;
        ent_t h;
        ent_t e;
        #1;
        elig    = alu_valid && !mpend[alu_dest];
        take_ld = !rst && mq.size() != 0 && (mq.size() == DEPTH || mstarve == LIM || !elig);
        e_alu   = !rst && elig && !take_ld;
        e_ld    = !rst && (mq.size() < DEPTH || take_ld);
        e_iss   = !rst && !mpend[ld_issue_dest];
        e_stall = (rd_addr1 != 0 && mpend[rd_addr1]) || (rd_addr2 != 0 && mpend[rd_addr2]);
        s_alu_ready   = alu_ready;
        s_ld_ready    = ld_ready;
        s_issue_ready = ld_issue_ready;
        s_stall       = hazard_stall;
        chk("alu_ready", 32'(alu_ready), 32'(e_alu));
        chk("ld_ready", 32'(ld_ready), 32'(e_ld));
        chk("ld_issue_ready", 32'(ld_issue_ready), 32'(e_iss));
        if (!rst) chk("hazard_stall", 32'(hazard_stall), 32'(e_stall));

        @(posedge clk);
        if (rst) begin
            mq.delete();
            foreach (mpend[i]) mpend[i] = 1'b0;
            mstarve  = 0;
            m_en     = 1'b0;
            m_dest   = '0;
            m_data   = '0;
            m_unsure = 1'b0;
        end else begin
            m_en = 1'b0;
            if (mq.size() != 0 && !take_ld) mstarve++;
            else mstarve = 0;
            if (take_ld) begin
                h = mq.pop_front();
                mpend[h.d] = 1'b0;
                m_en = (h.d != 0);
                m_dest = h.d;
                m_data = h.v;
                m_unsure = (h.d == 0);
            end else if (e_alu) begin
                m_en = (alu_dest != 0);
                m_dest = alu_dest;
                m_data = alu_data;
                m_unsure = (alu_dest == 0);
            end
            if (ld_issue && e_iss && ld_issue_dest != 0) mpend[ld_issue_dest] = 1'b1;
            if (ld_valid && e_ld) begin
                e.d = ld_dest;
                e.v = ld_data;
                mq.push_back(e);
            end
        end
        m_pc = 0;
        foreach (mpend[i]) m_pc += int'(mpend[i]);

        @(negedge clk);
        chk("rg_wrt_en", 32'(rg_wrt_en), 32'(m_en));
        chk("pend_count", 32'(pend_count), 32'(m_pc));
        if (!m_unsure) begin
            chk("rg_wrt_dest", 32'(rg_wrt_dest), 32'(m_dest));
            chk("rg_wrt_data", rg_wrt_data, m_data);
        end
    endtask

    task automatic idle();
        rst = 1'b0; alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_dest = '0; ld_valid = 1'b0; ld_dest = '0; ld_data = '0;
        rd_addr1 = '0; rd_addr2 = '0;
    endtask

    initial begin
        idle();
        // Reset held with a load issue pending: nothing may be reserved.
        rst = 1'b1; ld_issue = 1'b1; ld_issue_dest = 5'd5;
        cycle(); cycle();
        idle(); rd_addr1 = 5'd5;
        cycle();
        chk("rst_stall", 32'(hazard_stall), 32'd0);
        chk("rst_pend_count", 32'(pend_count), 32'd0);
        chk("rst_wrt_en", 32'(rg_wrt_en), 32'd0);

        // ALU only
        idle(); alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'hDEADBEEF;
        cycle();
        chk("alu_only_ready", 32'(s_alu_ready), 32'd1);
        chk("alu_only_en", 32'(rg_wrt_en), 32'd1);
        chk("alu_only_dest", 32'(rg_wrt_dest), 32'd3);
        chk("alu_only_data", rg_wrt_data, 32'hDEADBEEF);

        // Load hazard on x7
        idle(); ld_issue = 1'b1; ld_issue_dest = 5'd7;
        cycle();
        idle(); rd_addr1 = 5'd7;
        cycle();
        chk("hz_stall_set", 32'(s_stall), 32'd1);
        ld_valid = 1'b1; ld_dest = 5'd7; ld_data = 32'h80;
        cycle();
        ld_valid = 1'b0;
        cycle();
        chk("hz_stall_at_grant", 32'(s_stall), 32'd1);
        chk("hz_wr_en", 32'(rg_wrt_en), 32'd1);
        chk("hz_wr_dest", 32'(rg_wrt_dest), 32'd7);
        chk("hz_wr_data", rg_wrt_data, 32'h80);
        cycle();
        chk("hz_stall_clear", 32'(s_stall), 32'd0);

        // Starvation: one FIFO entry against a continuous ALU stream
        idle(); ld_issue = 1'b1; ld_issue_dest = 5'd10;
        cycle();
        idle(); ld_valid = 1'b1; ld_dest = 5'd10; ld_data = 32'h1234;
        alu_valid = 1'b1; alu_dest = 5'd4; alu_data = $urandom;
        cycle();
        chk("starve_push_alu", 32'(s_alu_ready), 32'd1);
        ld_valid = 1'b0;
        for (int i = 0; i < LIM; i++) begin
            alu_data = $urandom;
            cycle();
            chk("starve_alu_wins", 32'(s_alu_ready), 32'd1);
        end
        alu_data = $urandom;
        cycle();
        chk("starve_forced", 32'(s_alu_ready), 32'd0);
        chk("starve_wr_dest", 32'(rg_wrt_dest), 32'd10);
        chk("starve_wr_data", rg_wrt_data, 32'h1234);

        // FIFO full while the ALU is busy, then push on the forced pop
        ld_issue = 1'b1; ld_issue_dest = 5'd11;
        cycle();
        ld_issue_dest = 5'd12;
        cycle();
        ld_issue = 1'b0; ld_valid = 1'b1; ld_dest = 5'd11; ld_data = 32'h11;
        cycle();
        ld_dest = 5'd12; ld_data = 32'h12;
        cycle();
        ld_dest = 5'd13; ld_data = 32'h13;
        cycle();
        chk("full_push_on_pop", 32'(s_ld_ready), 32'd1);
        chk("full_alu_blocked", 32'(s_alu_ready), 32'd0);
        chk("full_wr_dest", 32'(rg_wrt_dest), 32'd11);
        idle();
        cycle(); cycle(); cycle();
        chk("full_drain_dest", 32'(rg_wrt_dest), 32'd13);

        // x0 write and WAW ordering on x9
        idle(); alu_valid = 1'b1; alu_dest = 5'd0; alu_data = $urandom;
        cycle();
        chk("x0_ready", 32'(s_alu_ready), 32'd1);
        chk("x0_wr_en", 32'(rg_wrt_en), 32'd0);
        idle(); ld_issue = 1'b1; ld_issue_dest = 5'd9;
        cycle();
        idle(); alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h99;
        cycle();
        chk("waw_blocked", 32'(s_alu_ready), 32'd0);
        ld_issue = 1'b1; ld_issue_dest = 5'd9;
        cycle();
        chk("second_issue_waits", 32'(s_issue_ready), 32'd0);
        ld_issue = 1'b0; ld_valid = 1'b1; ld_dest = 5'd9; ld_data = 32'h900;
        cycle();
        chk("waw_blocked_push", 32'(s_alu_ready), 32'd0);
        ld_valid = 1'b0;
        cycle();
        chk("waw_blocked_grant", 32'(s_alu_ready), 32'd0);
        chk("waw_ld_data", rg_wrt_data, 32'h900);
        cycle();
        chk("waw_released", 32'(s_alu_ready), 32'd1);
        chk("waw_alu_data", rg_wrt_data, 32'h99);

        // Randomized traffic on a narrow register range to force collisions
        for (int n = 0; n < 800; n++) begin
            rst           = ($urandom_range(0, 63) == 0);
            alu_valid     = 1'($urandom_range(0, 1));
            alu_dest      = 5'($urandom_range(0, 7));
            alu_data      = $urandom;
            ld_issue      = 1'($urandom_range(0, 1));
            ld_issue_dest = 5'($urandom_range(0, 7));
            ld_valid      = ($urandom_range(0, 2) == 0);
            ld_dest       = 5'($urandom_range(0, 7));
            ld_data       = $urandom;
            rd_addr1      = 5'($urandom_range(0, 7));
            rd_addr2      = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
